// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM for a multi-cycle RV32 subset core
// (R-type, I-type ALU, LW, SW, BEQ). Sequences a shared ALU, a unified
// memory and the register file over FETCH/DECODE/EXEC/MEM/WB cycles.
// Memory accesses use a ready handshake, and retired instructions are counted.
// Optional feature: define ILLEGAL_TRAP_EN to make unknown opcodes lock the
// FSM in a TRAP state with a sticky illegal_o flag. When it is undefined,
// unknown opcodes retire as NOPs.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [6:0]       opcode_i,
    input  logic             mem_ready_i,
    input  logic             halt_i,
    output logic             pc_write_o,
    output logic             ir_write_o,
    output logic             adr_src_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             reg_write_o,
    output logic [1:0]       alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [1:0]       alu_op_o,
    output logic [1:0]       result_src_o,
    output logic             branch_o,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] instret_o,
    output logic             illegal_o
);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_TRAP      = 4'd10
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             retire;
    logic [CNT_W-1:0] instret_q;

    // State register and retired-instruction counter; reset abandons any
    // in-flight instruction without counting it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    assign instret_o = instret_q;

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    // Sticky illegal-opcode flag, raised on the edge that enters TRAP.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            illegal_q <= 1'b0;
        end else if (state_d == S_TRAP) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal_o = illegal_q;
`else
    assign illegal_o = 1'b0;
`endif

    // Next-state logic and state-decoded datapath controls; reset forces all controls low.
    always_comb begin
        state_d      = state_q;
        retire       = 1'b0;
        pc_write_o   = 1'b0;
        ir_write_o   = 1'b0;
        adr_src_o    = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        reg_write_o  = 1'b0;
        alu_src_a_o  = 2'b00;
        alu_src_b_o  = 2'b00;
        alu_op_o     = 2'b00;
        result_src_o = 2'b00;
        branch_o     = 1'b0;
        state_o      = state_q;

        case (state_q)
            S_FETCH: begin
                alu_src_b_o  = 2'b10;
                result_src_o = 2'b10;
                if (!halt_i) begin
                    mem_read_o = 1'b1;
                    if (mem_ready_i) begin
                        pc_write_o = 1'b1;
                        ir_write_o = 1'b1;
                        state_d    = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b01;
                case (opcode_i)
                    OP_R:         state_d = S_EXEC_R;
                    OP_I:         state_d = S_EXEC_I;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BR:        state_d = S_BRANCH;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        state_d = S_TRAP;
`else
                        state_d = S_FETCH;
                        retire  = 1'b1;
`endif
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
                state_d     = (opcode_i == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_read_o = 1'b1;
                adr_src_o  = 1'b1;
                if (mem_ready_i) begin
                    state_d = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                reg_write_o  = 1'b1;
                result_src_o = 2'b01;
                state_d      = S_FETCH;
                retire       = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write_o = 1'b1;
                adr_src_o   = 1'b1;
                if (mem_ready_i) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXEC_R: begin
                alu_src_a_o = 2'b10;
                alu_op_o    = 2'b10;
                state_d     = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
                alu_op_o    = 2'b11;
                state_d     = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write_o = 1'b1;
                state_d     = S_FETCH;
                retire      = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_o = 2'b10;
                alu_op_o    = 2'b01;
                branch_o    = 1'b1;
                state_d     = S_FETCH;
                retire      = 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: begin
                state_d = S_TRAP;
            end
`endif
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (rst_i) begin
            pc_write_o   = 1'b0;
            ir_write_o   = 1'b0;
            adr_src_o    = 1'b0;
            mem_read_o   = 1'b0;
            mem_write_o  = 1'b0;
            reg_write_o  = 1'b0;
            alu_src_a_o  = 2'b00;
            alu_src_b_o  = 2'b00;
            alu_op_o     = 2'b00;
            result_src_o = 2'b00;
            branch_o     = 1'b0;
            state_o      = 4'd0;
            retire       = 1'b0;
        end
    end

endmodule
